fp_align_pipe: RTL

//   Parametrised, pipelined compare-and-align stage for the floating-point adder in the MAC datapath.
//   - Sorts two unpacked operands by magnitude.
//   - Right-shifts the smaller mantissa by the exponent difference, keeping guard/round/sticky bits.
//   - Emits the common exponent (+1 carry headroom) for the downstream add/normalise stage.
//   - Valid/ready handshake on both sides; 2-cycle latency; full throughput.

---
 rtl/fp_align_pipe.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fp_align_pipe.sv
// Two-stage compare-and-align front end for the FP adder.
// Stage 1 orders the operands by magnitude. Stage 2 shifts the smaller mantissa and keeps G/R/sticky.
module fp_align_pipe #(
  parameter int EW = 8,
  parameter int MW = 24
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic          sub_i,
  input  logic          s1_i,
  input  logic          s2_i,
  input  logic [EW-1:0] e1_i,
  input  logic [EW-1:0] e2_i,
  input  logic [MW-1:0] m1_i,
  input  logic [MW-1:0] m2_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [EW-1:0] ex_o,
  output logic          exp_ovf_o,
  output logic [MW+2:0] mx_o,
  output logic [MW+2:0] my_o,
  output logic          sx_o,
  output logic          sy_o,
  output logic          swap_o,
  output logic          eff_sub_o
);

  localparam int XW = MW + 3;
  localparam int DW = $clog2(XW + 1);

  logic adv1, adv2;

  logic          v1_q;
  logic          swap1_q, swap1_d;
  logic [DW-1:0] d1_q, d1_d;
  logic [MW-1:0] mBig1_q, mBig1_d;
  logic [MW-1:0] mSmall1_q, mSmall1_d;
  logic          sBig1_q, sBig1_d;
  logic          sSmall1_q, sSmall1_d;
  logic [EW-1:0] eBig1_q, eBig1_d;

  logic          v2_q;
  logic [EW-1:0] ex_q, ex_d;
  logic          expOvf_q, expOvf_d;
  logic [XW-1:0] mx_q, mx_d;
  logic [XW-1:0] my_q, my_d;
  logic          sx_q, sy_q;
  logic          swap2_q;

  logic          s2Eff;
  logic [EW-1:0] diff;
  logic [XW-1:0] ext, lowMask;
  logic          sticky;

  // A stage may load whenever it is empty or its contents are leaving this cycle.
  assign adv2       = !v2_q || out_ready_i;
  assign adv1       = !v1_q || adv2;
  assign in_ready_o = adv1;

  always_comb begin
    s2Eff     = s2_i ^ sub_i;
    swap1_d   = (e2_i > e1_i) || ((e2_i == e1_i) && (m2_i > m1_i));
    diff      = swap1_d ? (e2_i - e1_i) : (e1_i - e2_i);
    d1_d      = (int'(diff) > XW) ? DW'(XW) : DW'(diff);
    mBig1_d   = swap1_d ? m2_i : m1_i;
    mSmall1_d = swap1_d ? m1_i : m2_i;
    sBig1_d   = swap1_d ? s2Eff : s1_i;
    sSmall1_d = swap1_d ? s1_i : s2Eff;
    eBig1_d   = swap1_d ? e2_i : e1_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q      <= 1'b0;
      swap1_q   <= 1'b0;
      d1_q      <= '0;
      mBig1_q   <= '0;
      mSmall1_q <= '0;
      sBig1_q   <= 1'b0;
      sSmall1_q <= 1'b0;
      eBig1_q   <= '0;
    end else if (adv1) begin
      v1_q <= in_valid_i;
      if (in_valid_i) begin
        swap1_q   <= swap1_d;
        d1_q      <= d1_d;
        mBig1_q   <= mBig1_d;
        mSmall1_q <= mSmall1_d;
        sBig1_q   <= sBig1_d;
        sSmall1_q <= sSmall1_d;
        eBig1_q   <= eBig1_d;
      end
    end
  end

  // A saturated shift of XW empties the word, so the sticky then collects every bit.
  always_comb begin
    ext      = {mSmall1_q, 3'b000};
    lowMask  = ~({XW{1'b1}} << d1_q);
    sticky   = |(ext & lowMask);
    my_d     = (ext >> d1_q) | {{(XW-1){1'b0}}, sticky};
    mx_d     = {mBig1_q, 3'b000};
    ex_d     = eBig1_q + EW'(1);
    expOvf_d = &eBig1_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v2_q     <= 1'b0;
      ex_q     <= '0;
      expOvf_q <= 1'b0;
      mx_q     <= '0;
      my_q     <= '0;
      sx_q     <= 1'b0;
      sy_q     <= 1'b0;
      swap2_q  <= 1'b0;
    end else if (adv2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        ex_q     <= ex_d;
        expOvf_q <= expOvf_d;
        mx_q     <= mx_d;
        my_q     <= my_d;
        sx_q     <= sBig1_q;
        sy_q     <= sSmall1_q;
        swap2_q  <= swap1_q;
      end
    end
  end

  assign out_valid_o = v2_q;
  assign ex_o        = ex_q;
  assign exp_ovf_o   = expOvf_q;
  assign mx_o        = mx_q;
  assign my_o        = my_q;
  assign sx_o        = sx_q;
  assign sy_o        = sy_q;
  assign swap_o      = swap2_q;
  assign eff_sub_o   = sx_q ^ sy_q;

endmodule
